// File: rtl/riscv_bp_gshare.sv
// -----------------------------------------------------------------------------
// riscv_bp_gshare
// Table of saturating branch counters indexed by {GHR, PC bits} (INDEX_MODE=0)
// or PC bits XOR GHR (INDEX_MODE=1). Owns the global history register and
// walks the whole table to the weakly-not-taken value after every reset.
// Lookup is a one-cycle synchronous read keyed by the fetch PC; updates come
// from the branch unit at EX resolution and use the history captured at fetch.
// -----------------------------------------------------------------------------
module riscv_bp_gshare #(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned BP_GLOBAL_BITS    = 2,
    parameter int unsigned BP_LOCAL_BITS     = 10,
    parameter int unsigned BP_LOCAL_BITS_LSB = 2,
    parameter int unsigned CNT_BITS          = 2,
    parameter int unsigned INDEX_MODE        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      id_stall_i,
    input  logic [XLEN-1:0]           if_parcel_pc_i,
    output logic [CNT_BITS-1:0]       bp_bp_predict_o,
    output logic [BP_GLOBAL_BITS-1:0] bp_history_o,
    output logic                      bp_init_busy_o,
    input  logic [XLEN-1:0]           ex_pc_i,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
    input  logic [CNT_BITS-1:0]       bu_bp_predict_i,
    input  logic                      bu_bp_btaken_i,
    input  logic                      bu_bp_update_i
);

    localparam int unsigned GHR_W = BP_GLOBAL_BITS;
    localparam int unsigned LOC_W = BP_LOCAL_BITS;
    localparam int unsigned CNT_W = CNT_BITS;
    localparam int unsigned IDX_W = (INDEX_MODE == 0) ? (GHR_W + LOC_W) : LOC_W;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] INIT_VAL  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN   = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] WALK_LAST = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Table index from a PC and a history value, according to INDEX_MODE.
    function automatic logic [IDX_W-1:0] make_idx(
        input logic [XLEN-1:0]  pc,
        input logic [GHR_W-1:0] hist
    );
        logic [LOC_W-1:0] pc_bits;
        logic [IDX_W-1:0] idx;
        pc_bits = pc[BP_LOCAL_BITS_LSB +: LOC_W];
        if (INDEX_MODE == 0) begin
            idx = IDX_W'({hist, pc_bits});
        end else begin
            idx = IDX_W'(pc_bits ^ LOC_W'(hist));
        end
        return idx;
    endfunction

    // Saturating increment/decrement of a counter; never wraps.
    function automatic logic [CNT_W-1:0] sat_next(
        input logic [CNT_W-1:0] cnt,
        input logic             taken
    );
        logic [CNT_W-1:0] res;
        if (taken) begin
            if (cnt == CNT_MAX) begin
                res = CNT_MAX;
            end else begin
                res = cnt + CNT_W'(1'b1);
            end
        end else begin
            if (cnt == CNT_MIN) begin
                res = CNT_MIN;
            end else begin
                res = cnt - CNT_W'(1'b1);
            end
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   walk_q, walk_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [CNT_W-1:0]   predict_q, predict_d;

    // Counter storage: no reset, cleared by the INIT walk instead.
    logic [CNT_W-1:0]   table_q [DEPTH];

    logic [IDX_W-1:0]   rd_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic [CNT_W-1:0]   upd_val_s;
    logic               upd_en_s;
    logic               bypass_s;
    logic [CNT_W-1:0]   rd_data_s;
    logic               we_s;
    logic [IDX_W-1:0]   waddr_s;
    logic [CNT_W-1:0]   wdata_s;

    // Address bits outside the index window are intentionally ignored.
    logic               unused_pc_s;
    assign unused_pc_s = ^{if_parcel_pc_i, ex_pc_i};

    // Read index uses the live GHR; write index uses the history captured at fetch.
    always_comb begin
        rd_idx_s  = make_idx(if_parcel_pc_i, ghr_q);
        wr_idx_s  = make_idx(ex_pc_i, bu_bp_history_i);
        upd_val_s = sat_next(bu_bp_predict_i, bu_bp_btaken_i);
        upd_en_s  = (state_q == ST_RUN) && bu_bp_update_i;
        bypass_s  = upd_en_s && (rd_idx_s == wr_idx_s);
        rd_data_s = table_q[rd_idx_s];
    end

    // Single write port: the INIT walk owns it, otherwise the EX update does.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = walk_q;
        wdata_s = INIT_VAL;
        if (state_q == ST_INIT) begin
            we_s    = 1'b1;
            waddr_s = walk_q;
            wdata_s = INIT_VAL;
        end else if (upd_en_s) begin
            we_s    = 1'b1;
            waddr_s = wr_idx_s;
            wdata_s = upd_val_s;
        end else begin
            we_s    = 1'b0;
            waddr_s = walk_q;
            wdata_s = INIT_VAL;
        end
    end

    // Counter table write port.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            table_q[waddr_s] <= wdata_s;
        end
    end

    // Next state: walk every entry once, then run until the next reset.
    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        case (state_q)
            ST_INIT: begin
                walk_d = walk_q + IDX_W'(1'b1);
                if (walk_q == WALK_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                walk_d  = walk_q;
            end
            default: begin
                state_d = ST_INIT;
                walk_d  = {IDX_W{1'b0}};
            end
        endcase
    end

    // GHR shifts in the resolved outcome only on an accepted update strobe.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en_s) begin
            ghr_d = GHR_W'({ghr_q, bu_bp_btaken_i});
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Prediction: INIT value while walking, hold on stall, write-first on collision.
    always_comb begin
        predict_d = predict_q;
        if (state_q == ST_INIT) begin
            predict_d = INIT_VAL;
        end else if (id_stall_i) begin
            predict_d = predict_q;
        end else if (bypass_s) begin
            predict_d = upd_val_s;
        end else begin
            predict_d = rd_data_s;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_INIT;
            walk_q    <= {IDX_W{1'b0}};
            ghr_q     <= {GHR_W{1'b0}};
            predict_q <= INIT_VAL;
        end else begin
            state_q   <= state_d;
            walk_q    <= walk_d;
            ghr_q     <= ghr_d;
            predict_q <= predict_d;
        end
    end

    assign bp_bp_predict_o = predict_q;
    assign bp_history_o    = ghr_q;
    assign bp_init_busy_o  = (state_q == ST_INIT);

endmodule

// File: tb/tb_riscv_bp_gshare.sv
// -----------------------------------------------------------------------------
// Testbench for riscv_bp_gshare: instance A in concat mode (G=2, L=10, C=2),
// instance B in gshare mode (G=2, L=4, C=3). Expected values are queued when
// stimulus is driven and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_riscv_bp_gshare;

    logic        clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instance A signals
    logic        rst_na, stall_a, btaken_a, upd_a, busy_a;
    logic [31:0] pc_a, ex_pc_a;
    logic [1:0]  pred_a, hist_a, bu_hist_a, bu_pred_a;

    // Instance B signals
    logic        rst_nb, stall_b, btaken_b, upd_b, busy_b;
    logic [31:0] pc_b, ex_pc_b;
    logic [2:0]  pred_b, bu_pred_b;
    logic [1:0]  hist_b, bu_hist_b;

    riscv_bp_gshare #(
        .XLEN(32), .BP_GLOBAL_BITS(2), .BP_LOCAL_BITS(10),
        .BP_LOCAL_BITS_LSB(2), .CNT_BITS(2), .INDEX_MODE(0)
    ) u_dut_a (
        .clk_i          (clk_i),
        .rst_ni         (rst_na),
        .id_stall_i     (stall_a),
        .if_parcel_pc_i (pc_a),
        .bp_bp_predict_o(pred_a),
        .bp_history_o   (hist_a),
        .bp_init_busy_o (busy_a),
        .ex_pc_i        (ex_pc_a),
        .bu_bp_history_i(bu_hist_a),
        .bu_bp_predict_i(bu_pred_a),
        .bu_bp_btaken_i (btaken_a),
        .bu_bp_update_i (upd_a)
    );

    riscv_bp_gshare #(
        .XLEN(32), .BP_GLOBAL_BITS(2), .BP_LOCAL_BITS(4),
        .BP_LOCAL_BITS_LSB(2), .CNT_BITS(3), .INDEX_MODE(1)
    ) u_dut_b (
        .clk_i          (clk_i),
        .rst_ni         (rst_nb),
        .id_stall_i     (stall_b),
        .if_parcel_pc_i (pc_b),
        .bp_bp_predict_o(pred_b),
        .bp_history_o   (hist_b),
        .bp_init_busy_o (busy_b),
        .ex_pc_i        (ex_pc_b),
        .bu_bp_history_i(bu_hist_b),
        .bu_bp_predict_i(bu_pred_b),
        .bu_bp_btaken_i (btaken_b),
        .bu_bp_update_i (upd_b)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input string t, input logic [15:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %0h expected <none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic a_upd(input logic [31:0] pc, input logic [1:0] h,
                         input logic [1:0] p, input logic tk);
        upd_a = 1'b1; ex_pc_a = pc; bu_hist_a = h; bu_pred_a = p; btaken_a = tk;
    endtask

    task automatic b_upd(input logic [31:0] pc, input logic [1:0] h,
                         input logic [2:0] p, input logic tk);
        upd_b = 1'b1; ex_pc_b = pc; bu_hist_b = h; bu_pred_b = p; btaken_b = tk;
    endtask

    // Reference 2-bit saturating counter.
    function automatic logic [1:0] ref_sat2(input logic [1:0] c, input logic tk);
        int v;
        v = int'(c) + (tk ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    initial begin
        int          n, na, nb;
        logic        ok_a, ok_b;
        logic [1:0]  cur, nxt;

        rst_na = 1'b0; stall_a = 1'b0; pc_a = 32'h0; ex_pc_a = 32'h0;
        bu_hist_a = 2'b00; bu_pred_a = 2'b00; btaken_a = 1'b0; upd_a = 1'b0;
        rst_nb = 1'b0; stall_b = 1'b0; pc_b = 32'h0; ex_pc_b = 32'h0;
        bu_hist_b = 2'b00; bu_pred_b = 3'b000; btaken_b = 1'b0; upd_b = 1'b0;
        repeat (2) tick();

        // Reset values
        push("rst_pred_a", 16'h1);  pop_cmp(16'(pred_a));
        push("rst_hist_a", 16'h0);  pop_cmp(16'(hist_a));
        push("rst_busy_a", 16'h1);  pop_cmp(16'(busy_a));
        push("rst_pred_b", 16'h3);  pop_cmp(16'(pred_b));
        push("rst_busy_b", 16'h1);  pop_cmp(16'(busy_b));

        // INIT walk, with update strobes on A that must be ignored
        a_upd(32'h204, 2'b00, 2'b01, 1'b1);
        rst_na = 1'b1; rst_nb = 1'b1;
        n = 0; na = 0; nb = 0; ok_a = 1'b1; ok_b = 1'b1;
        while ((na == 0 || nb == 0) && n < 6000) begin
            tick();
            n++;
            if (!busy_a && na == 0) na = n;
            if (!busy_b && nb == 0) nb = n;
            if (busy_a && pred_a !== 2'b01)  ok_a = 1'b0;
            if (busy_b && pred_b !== 3'b011) ok_b = 1'b0;
        end
        upd_a = 1'b0;
        push("init_len_a", 16'd4096); pop_cmp(16'(na));
        push("init_len_b", 16'd16);   pop_cmp(16'(nb));
        push("init_pred_a", 16'h1);   pop_cmp(16'(ok_a));
        push("init_pred_b", 16'h1);   pop_cmp(16'(ok_b));
        push("init_ghr_a", 16'h0);    pop_cmp(16'(hist_a));

        // Concat index: update {00,0x081} 01->10, GHR -> 01
        pc_a = 32'h1000;
        a_upd(32'h204, 2'b00, 2'b01, 1'b1);
        push("ghr_after_upd", 16'h1);
        tick(); pop_cmp(16'(hist_a));
        upd_a = 1'b0; pc_a = 32'h204;
        push("rd_ghr01", 16'h1);
        tick(); pop_cmp(16'(pred_a));
        // Two not-taken updates elsewhere bring GHR back to 00
        a_upd(32'h800, 2'b01, 2'b01, 1'b0); tick();
        a_upd(32'h800, 2'b10, 2'b01, 1'b0); tick();
        upd_a = 1'b0;
        push("ghr_back00", 16'h0); pop_cmp(16'(hist_a));
        push("rd_ghr00", 16'h2);
        tick(); pop_cmp(16'(pred_a));

        // Taken saturation on {11,0x0C0}, starting at 10
        a_upd(32'h900, 2'b00, 2'b01, 1'b1); tick();
        a_upd(32'h900, 2'b00, 2'b01, 1'b1); tick();
        cur = 2'b10;
        for (int i = 0; i < 4; i++) begin
            pc_a = 32'h1000;
            a_upd(32'h300, 2'b11, cur, 1'b1);
            tick();
            upd_a = 1'b0; pc_a = 32'h300;
            nxt = ref_sat2(cur, 1'b1);
            push("sat_taken", 16'(nxt));
            tick(); pop_cmp(16'(pred_a));
            cur = nxt;
        end

        // Not-taken saturation on {00,0x100}, starting at 01
        a_upd(32'h900, 2'b11, 2'b01, 1'b0); tick();
        a_upd(32'h900, 2'b11, 2'b01, 1'b0); tick();
        cur = 2'b01;
        for (int i = 0; i < 4; i++) begin
            pc_a = 32'h1000;
            a_upd(32'h400, 2'b00, cur, 1'b0);
            tick();
            upd_a = 1'b0; pc_a = 32'h400;
            nxt = ref_sat2(cur, 1'b0);
            push("sat_not_taken", 16'(nxt));
            tick(); pop_cmp(16'(pred_a));
            cur = nxt;
        end

        // Read/write collision: write-first bypass
        pc_a = 32'h500;
        a_upd(32'h500, 2'b00, 2'b10, 1'b1);
        push("collision", 16'h3);
        tick(); pop_cmp(16'(pred_a));
        upd_a = 1'b0;
        push("collision_ghr", 16'h1); pop_cmp(16'(hist_a));

        // Stall: prepare {11,0x1C0}=11, show 01, then stall onto that PC
        pc_a = 32'h600;
        a_upd(32'h700, 2'b11, 2'b10, 1'b1);
        tick();
        upd_a = 1'b0;
        push("pre_stall", 16'h1);
        tick(); pop_cmp(16'(pred_a));
        stall_a = 1'b1; pc_a = 32'h700;
        for (int i = 0; i < 3; i++) begin
            push("stall_hold", 16'h1);
            tick(); pop_cmp(16'(pred_a));
        end
        stall_a = 1'b0;
        push("post_stall", 16'h3);
        tick(); pop_cmp(16'(pred_a));

        // Gshare instance: GHR -> 11, then PC 0x0C with history 11 hits entry 0
        b_upd(32'h30, 2'b00, 3'b011, 1'b1); tick();
        b_upd(32'h30, 2'b01, 3'b011, 1'b1); tick();
        upd_b = 1'b0;
        push("b_ghr11", 16'h3); pop_cmp(16'(hist_b));
        pc_b = 32'h30;
        b_upd(32'h0C, 2'b11, 3'b011, 1'b1);
        tick();
        upd_b = 1'b0; pc_b = 32'h0C;
        push("b_idx0", 16'h4);
        tick(); pop_cmp(16'(pred_b));
        pc_b = 32'h00;
        push("b_idx3", 16'h3);
        tick(); pop_cmp(16'(pred_b));

        // Reset mid-RUN restarts the 16-cycle INIT and clears the table
        #2;
        rst_nb = 1'b0;
        #1;
        push("b_rst_busy", 16'h1); pop_cmp(16'(busy_b));
        push("b_rst_pred", 16'h3); pop_cmp(16'(pred_b));
        push("b_rst_hist", 16'h0); pop_cmp(16'(hist_b));
        tick();
        rst_nb = 1'b1;
        n = 0; nb = 0;
        while (nb == 0 && n < 100) begin
            tick();
            n++;
            if (!busy_b) nb = n;
        end
        push("b_reinit_len", 16'd16); pop_cmp(16'(nb));
        push("b_idx0_cleared", 16'h3);
        tick(); pop_cmp(16'(pred_b));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
